// File: rtl/sync_pkg.sv
// sync_pkg: shared edge-select encoding and legal synchronizer depth bounds.
package sync_pkg;
  typedef enum int {EDGE_RISE = 0, EDGE_ANY = 1, EDGE_FALL = 2} edge_sel_e;
  localparam int SYNC_MIN_FF = 2;
  localparam int SYNC_MAX_FF = 8;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: NUM_FF-stage async-reset shift register for a single-bit CDC crossing.
module sync_chain #(
  parameter int NUM_FF = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  // Pure flop-to-flop chain so the tools can place the stages adjacently.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [NUM_FF-1:0] r_stage;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_stage <= '0;
    else          r_stage <= {r_stage[NUM_FF-2:0], i_d};
  assign o_q = r_stage[NUM_FF-1];
endmodule

// File: rtl/synchronize_bit.sv
// synchronize_bit: single-bit CDC synchronizer with a one-cycle edge-detect pulse
// on the selected edge of the synchronized data.
module synchronize_bit import sync_pkg::*; #(
  parameter int NUM_FF   = 2,
  parameter int EDGE_SEL = 1
) (
  input  logic dest_clk,
  input  logic rstn,
  input  logic D_in,
  output logic D_out,
  output logic sync_pulse
);
  if (NUM_FF < SYNC_MIN_FF || NUM_FF > SYNC_MAX_FF) begin : g_bad_depth
    $error("synchronize_bit: NUM_FF=%0d outside 2..8", NUM_FF);
  end
  if (EDGE_SEL < int'(EDGE_RISE) || EDGE_SEL > int'(EDGE_FALL)) begin : g_bad_edge
    $error("synchronize_bit: EDGE_SEL=%0d is not 0, 1 or 2", EDGE_SEL);
  end
  logic r_d_prev;
  sync_chain #(.NUM_FF(NUM_FF)) u_chain (
    .i_clk  (dest_clk),
    .i_rst_n(rstn),
    .i_d    (D_in),
    .o_q    (D_out)
  );
  always_ff @(posedge dest_clk or negedge rstn)
    if (!rstn) r_d_prev <= 1'b0;
    else       r_d_prev <= D_out;
  // Both operands are registered, so the decoded pulse is glitch-free.
  always_comb
    sync_pulse = (EDGE_SEL == int'(EDGE_RISE)) ? (D_out & ~r_d_prev) :
                 (EDGE_SEL == int'(EDGE_ANY))  ? (D_out ^ r_d_prev)  :
                                                 (~D_out & r_d_prev);
endmodule

// File: tb/tb_synchronize_bit.sv
// tb_synchronize_bit: scoreboard bench over several depth/edge-select variants
// sharing one clock, reset and data input.
module tb_synchronize_bit;
  localparam int N = 5;
  localparam int NFF [N] = '{3, 3, 3, 2, 8};
  localparam int ESEL[N] = '{1, 0, 2, 1, 1};
  typedef struct {int cyc; bit val;} ev_t;
  logic dest_clk = 1'b0;
  logic rstn = 1'b1;
  logic D_in = 1'b0;
  logic [N-1:0] d_out, pulse;
  ev_t sb[N][$];
  ev_t e;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #6 dest_clk = ~dest_clk;
  always @(posedge dest_clk) cyc <= cyc + 1;

  synchronize_bit #(.NUM_FF(3), .EDGE_SEL(1)) u0 (.dest_clk(dest_clk), .rstn(rstn), .D_in(D_in), .D_out(d_out[0]), .sync_pulse(pulse[0]));
  synchronize_bit #(.NUM_FF(3), .EDGE_SEL(0)) u1 (.dest_clk(dest_clk), .rstn(rstn), .D_in(D_in), .D_out(d_out[1]), .sync_pulse(pulse[1]));
  synchronize_bit #(.NUM_FF(3), .EDGE_SEL(2)) u2 (.dest_clk(dest_clk), .rstn(rstn), .D_in(D_in), .D_out(d_out[2]), .sync_pulse(pulse[2]));
  synchronize_bit #(.NUM_FF(2), .EDGE_SEL(1)) u3 (.dest_clk(dest_clk), .rstn(rstn), .D_in(D_in), .D_out(d_out[3]), .sync_pulse(pulse[3]));
  synchronize_bit #(.NUM_FF(8), .EDGE_SEL(1)) u4 (.dest_clk(dest_clk), .rstn(rstn), .D_in(D_in), .D_out(d_out[4]), .sync_pulse(pulse[4]));

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %b want %b (cyc %0d)", name, idx, act, exp, cyc);
    end
  endtask

  task automatic check_all(input string name, input logic exp_dout, input logic exp_pulse);
    for (int i = 0; i < N; i++) begin
      check({name, "_dout"}, i, d_out[i], exp_dout);
      check({name, "_pulse"}, i, pulse[i], exp_pulse);
    end
  endtask

  // A change applied while cyc==c is captured at edge c+1 and shows at edge c+NUM_FF.
  function automatic void push(input bit v);
    for (int i = 0; i < N; i++)
      if (ESEL[i] == 1 || (ESEL[i] == 0 && v) || (ESEL[i] == 2 && !v))
        sb[i].push_back(ev_t'{cyc + NFF[i], v});
  endfunction

  task automatic drive(input bit v);
    @(negedge dest_clk);
    if (D_in !== v) begin
      D_in = v;
      push(v);
    end
  endtask

  always @(negedge dest_clk)
    for (int i = 0; i < N; i++)
      if (pulse[i] !== 1'b0) begin
        total++;
        if (sb[i].size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse dut%0d: got pulse=%b want 0 (cyc %0d)", i, pulse[i], cyc);
        end else begin
          e = sb[i].pop_front();
          if (e.cyc != cyc || d_out[i] !== e.val) begin
            bad++;
            $display("FAIL pulse dut%0d: got cyc=%0d d_out=%b want cyc=%0d d_out=%b", i, cyc, d_out[i], e.cyc, e.val);
          end
        end
      end

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge dest_clk);
      check_all("reset_hold", 1'b0, 1'b0);
      D_in = ~D_in;
    end
    #4 rstn = 1'b1;
    repeat (4) @(negedge dest_clk);
    check_all("post_reset", 1'b0, 1'b0);
    drive(1'b1);
    repeat (10) @(negedge dest_clk);
    check_all("rise_level", 1'b1, 1'b0);
    drive(1'b0);
    repeat (10) @(negedge dest_clk);
    check_all("fall_level", 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(~D_in);
      repeat (7) @(negedge dest_clk);
    end
    repeat (10) @(negedge dest_clk);
    check_all("toggle_end", 1'b0, 1'b0);
    drive(1'b1);
    repeat (12) @(negedge dest_clk);
    check_all("pre_abort", 1'b1, 1'b0);
    drive(1'b0);
    @(posedge dest_clk);
    #3;
    D_in = 1'b1;
    rstn = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 1'b0);
    for (int i = 0; i < N; i++) sb[i].delete();
    repeat (3) @(negedge dest_clk);
    check_all("reset_held", 1'b0, 1'b0);
    @(negedge dest_clk);
    rstn = 1'b1;
    push(1'b1);
    repeat (12) @(negedge dest_clk);
    check_all("release_high", 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++;
      if (sb[i].size() != 0) begin
        bad++;
        $display("FAIL missing_pulses dut%0d: got %0d pending want 0", i, sb[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/synchronize_bit.md
Name: synchronize_bit

Overview:
- Single-bit clock-domain-crossing synchronizer. An asynchronous input is captured into the destination domain through a parameterizable flip-flop chain.
- Also produces a one-cycle edge-detect pulse in the destination domain.
- Sits at every single-bit CDC boundary, e.g. slow-domain flags or toggle signals entering a fast domain.
- Input must be a level or toggle held at least NUM_FF+1 dest_clk periods; no handshake back to the source.

Parameters:
- NUM_FF, 2, number of synchronizer stages (legal range 2..8; elaboration error outside this range).
- EDGE_SEL, 1, sync_pulse edge select:
  - 0 = rising edge of synchronized data.
  - 1 = any edge (toggle).
  - 2 = falling edge.
  - Other values are an elaboration error.

Ports:
- dest_clk  input  1  destination-domain clock; all state updates on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- D_in  input  1  asynchronous data input from the source domain.
- D_out  output  1  synchronized data, registered.
- sync_pulse  output  1  one-dest_clk-cycle pulse on the selected edge of D_out.

Behaviour:
- Reset (rstn=0), asynchronous:
  - All NUM_FF chain flops and the history flop d_prev clear to 0 immediately.
  - D_out=0 and sync_pulse=0 while reset is held.
- Chain:
  - stage[0] <= D_in.
  - stage[i] <= stage[i-1].
  - D_out = stage[NUM_FF-1].
- Latency: a D_in change stable before dest_clk edge k appears on D_out after edge k+NUM_FF-1, i.e. NUM_FF dest_clk edges inclusive of the capture edge. Metastability at stage[0] may add one cycle of uncertainty.
- History: d_prev <= D_out each dest_clk edge.
- sync_pulse is combinational from D_out and d_prev (both registered, so glitch-free):
  - EDGE_SEL=0: D_out & ~d_prev.
  - EDGE_SEL=1: D_out ^ d_prev.
  - EDGE_SEL=2: ~D_out & d_prev.
- Pulse width: exactly one dest_clk period per qualifying transition of D_out. It is high in the cycle D_out first shows the new value.
- Back-to-back toggles: D_in toggling faster than one dest_clk period may be lost. This is not detected, and it is a source-side requirement not to do it.
- Reset release with D_in=1: D_out rises NUM_FF edges after release. For EDGE_SEL 0/1 this yields one rising pulse; this is intended.
- Reset mid-operation clears the chain instantly. Any in-flight transition is discarded and no pulse is produced while rstn=0.
- Synthesis attributes: the chain registers are marked ASYNC_REG / dont_touch. No logic is allowed between chain stages.

Decomposition:
- Package sync_pkg holds:
  - typedef enum edge_sel_e {EDGE_RISE=0, EDGE_ANY=1, EDGE_FALL=2}.
  - localparams SYNC_MIN_FF=2 and SYNC_MAX_FF=8.
- One natural sub-module: sync_chain (NUM_FF-stage shift register with async reset, no logic). synchronize_bit wraps it and adds d_prev and the pulse decode.

Test Plan (NUM_FF=3, EDGE_SEL=1, dest_clk period 12 ns, source toggle period 100 ns, rstn low 0–100 ns):
- Reset hold: rstn=0 for 100 ns with D_in toggling -> D_out=0 and sync_pulse=0 throughout; no X after the first dest_clk edge.
- Rise latency: D_in 0->1 settles between edges -> D_out=1 exactly 3 dest_clk edges later; sync_pulse=1 for exactly one 12 ns cycle, aligned to the D_out change.
- Fall, toggle mode: D_in 1->0 -> D_out=0 after 3 edges; one 12 ns pulse. Over 1 µs of 100 ns toggling, the pulse count equals the D_in transition count (10) and the pulses are about 100 ns apart.
- Edge selects: rerun with EDGE_SEL=0 -> pulses only on D_out rising. EDGE_SEL=2 -> pulses only on falling. Pulse count is 5 each over 1 µs.
- Async reset mid-flight: rstn=0 one edge after D_in rises -> D_out and sync_pulse go 0 immediately (no clock needed). After release with D_in=1, D_out=1 after 3 edges plus one pulse.
- Depth sweep: NUM_FF=2 and 8 -> D_out latency of 2 and 8 edges respectively; pulse width always 1 cycle.
